// File: rtl/memory.sv
// memory: unified 64 KiB byte-addressed little-endian instruction/data memory.
//
// Ports
//   clk          : clock for the data port and all stores
//   clk_pc       : instruction-port clock, tied to the same net as clk
//   rst          : asynchronous active-low reset of the two output registers
//   address      : data-port byte address, bits [15:0] used
//   data         : store data
//   writeMode    : store mode (NONE/BYTE/HALFWORD/WORD/WORDLEFT/WORDRIGHT)
//   readMode     : load mode, same encoding
//   unsignedLoad : zero-extend (1) or sign-extend (0) BYTE/HALFWORD loads
//   pcAddress    : instruction byte address, bits [15:2] select the word
//   dataOutput   : registered load result, 1-cycle latency
//   pcDataOutput : registered instruction word, 1-cycle latency
//
// Storage is 16384 x 32-bit words with per-lane byte enables. Contents are
// never cleared; reset only affects the output registers, and stores keep
// committing while reset is asserted.
module memory (
    input  logic        clk,
    input  logic        clk_pc,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] data,
    input  logic [2:0]  writeMode,
    input  logic [2:0]  readMode,
    input  logic        unsignedLoad,
    input  logic [31:0] pcAddress,
    output logic [31:0] dataOutput,
    output logic [31:0] pcDataOutput
);

    typedef enum logic [2:0] {
        MODE_NONE      = 3'd0,
        MODE_BYTE      = 3'd1,
        MODE_HALFWORD  = 3'd2,
        MODE_WORD      = 3'd3,
        MODE_WORDLEFT  = 3'd4,
        MODE_WORDRIGHT = 3'd5
    } mode_e;

    logic [31:0] mem [0:16383];

    mode_e       wmode;
    mode_e       rmode;
    logic [13:0] word_idx;
    logic [1:0]  lane;

    logic [31:0] wr_word;
    logic [3:0]  byte_en;

    logic [31:0] rd_word;
    logic [31:0] rd_right;
    logic [31:0] rd_left;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    logic        unused_bits;

    assign wmode    = mode_e'(writeMode);
    assign rmode    = mode_e'(readMode);
    assign word_idx = address[15:2];
    assign lane     = address[1:0];

    assign unused_bits = ^{address[31:16], pcAddress[31:16], pcAddress[1:0]};

    // Store lane steering. ~lane equals 3-lane for a 2-bit lane index, so
    // swl shifts data right by 3-lane bytes and enables lanes lane..0,
    // while swr shifts left by lane bytes and enables lanes 3..lane.
    always_comb begin
        wr_word = '0;
        byte_en = '0;
        case (wmode)
            MODE_BYTE: begin
                wr_word = {4{data[7:0]}};
                byte_en = 4'b0001 << lane;
            end
            MODE_HALFWORD: begin
                wr_word = {2{data[15:0]}};
                byte_en = address[1] ? 4'b1100 : 4'b0011;
            end
            MODE_WORD: begin
                wr_word = data;
                byte_en = '1;
            end
            MODE_WORDLEFT: begin
                wr_word = data >> {~lane, 3'b000};
                byte_en = 4'b1111 >> ~lane;
            end
            MODE_WORDRIGHT: begin
                wr_word = data << {lane, 3'b000};
                byte_en = 4'b1111 << lane;
            end
            default: begin
                wr_word = '0;
                byte_en = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // Load formatting. lwl/lwr place the addressed lanes at the top/bottom
    // of the result with zero fill; callers do the register merge.
    always_comb begin
        rd_word  = mem[word_idx];
        rd_right = rd_word >> {lane, 3'b000};
        rd_left  = rd_word << {~lane, 3'b000};
        rd_half  = address[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = '0;
        case (rmode)
            MODE_BYTE: begin
                load_val = unsignedLoad ? {24'h0, rd_right[7:0]}
                                        : {{24{rd_right[7]}}, rd_right[7:0]};
            end
            MODE_HALFWORD: begin
                load_val = unsignedLoad ? {16'h0, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
            end
            MODE_WORD:      load_val = rd_word;
            MODE_WORDLEFT:  load_val = rd_left;
            MODE_WORDRIGHT: load_val = rd_right;
            default:        load_val = '0;
        endcase
    end

    // Non-blocking store above gives read-before-write on both ports.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOutput <= '0;
        end else begin
            dataOutput <= load_val;
        end
    end

    always_ff @(posedge clk_pc or negedge rst) begin
        if (!rst) begin
            pcDataOutput <= '0;
        end else begin
            pcDataOutput <= mem[pcAddress[15:2]];
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb_memory: self-checking bench for memory.
//
// Directed table of load/store records, hand-written PC-port and reset
// sequences, then randomized traffic checked against a byte-array model.
module tb_memory;

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_BYTE  = 3'd1;
    localparam logic [2:0] M_HALF  = 3'd2;
    localparam logic [2:0] M_WORD  = 3'd3;
    localparam logic [2:0] M_LEFT  = 3'd4;
    localparam logic [2:0] M_RIGHT = 3'd5;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] data;
    logic [2:0]  writeMode;
    logic [2:0]  readMode;
    logic        unsignedLoad;
    logic [31:0] pcAddress;
    logic [31:0] dataOutput;
    logic [31:0] pcDataOutput;

    int total = 0;
    int bad   = 0;

    memory dut (
        .clk          (clk),
        .clk_pc       (clk),
        .rst          (rst),
        .address      (address),
        .data         (data),
        .writeMode    (writeMode),
        .readMode     (readMode),
        .unsignedLoad (unsignedLoad),
        .pcAddress    (pcAddress),
        .dataOutput   (dataOutput),
        .pcDataOutput (pcDataOutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  wm;
        logic [2:0]  rm;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] dat;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic [2:0] wm, logic [2:0] rm, logic uns,
                                logic [31:0] a, logic [31:0] d,
                                logic chk, logic [31:0] e);
        vec_t v;
        v.wm = wm; v.rm = rm; v.uns = uns; v.addr = a; v.dat = d;
        v.chk = chk; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic void st(logic [2:0] wm, logic [31:0] a, logic [31:0] d);
        add(wm, M_NONE, 1'b0, a, d, 1'b0, 32'h0);
    endfunction

    function automatic void ld(logic [2:0] rm, logic uns, logic [31:0] a, logic [31:0] e);
        add(M_NONE, rm, uns, a, 32'h0, 1'b1, e);
    endfunction

    function automatic void build_table();
        logic [31:0] lwl_exp [4];
        logic [31:0] sw_exp  [4];
        logic [31:0] lwr_exp [4];
        logic [31:0] sr_exp  [4];
        lwl_exp = '{32'h12000000, 32'h12340000, 32'h12345600, 32'h12345678};
        sw_exp  = '{32'h00000012, 32'h00001234, 32'h00123456, 32'h12345678};
        sr_exp  = '{32'h78000000, 32'h56780000, 32'h34567800, 32'h12345678};
        lwr_exp = '{32'h00000078, 32'h00005678, 32'h00345678, 32'h12345678};
        // WORD
        st(M_WORD, 65532, 32'h22345678);
        st(M_WORD, 65528, 32'h0);
        ld(M_WORD, 0, 65532, 32'h22345678);
        ld(M_WORD, 0, 65528, 32'h0);
        // HALFWORD
        st(M_WORD, 65524, 32'h0);
        st(M_WORD, 65532, 32'h0);
        st(M_WORD, 65528, 32'h33333333);
        st(M_HALF, 65528, 32'h00001FFF);
        ld(M_WORD, 0, 65528, 32'h33331FFF);
        st(M_HALF, 65528, 32'h0000FFFF);
        ld(M_HALF, 0, 65528, 32'hFFFFFFFF);
        ld(M_HALF, 1, 65528, 32'h0000FFFF);
        st(M_HALF, 65528, 32'h0000ABCD);
        st(M_HALF, 65530, 32'h00009845);
        ld(M_WORD, 0, 65528, 32'h9845ABCD);
        ld(M_HALF, 1, 65531, 32'h00009845);
        ld(M_WORD, 0, 65524, 32'h0);
        ld(M_WORD, 0, 65532, 32'h0);
        // BYTE
        st(M_BYTE, 65530, 32'hFFFFFFB2);
        st(M_BYTE, 65528, 32'h000000D4);
        st(M_BYTE, 65531, 32'h123456A1);
        st(M_BYTE, 65529, 32'h000000C3);
        ld(M_WORD, 0, 65528, 32'hA1B2C3D4);
        ld(M_BYTE, 1, 65529, 32'h000000C3);
        ld(M_BYTE, 0, 65531, 32'hFFFFFFA1);
        ld(M_BYTE, 0, 65528, 32'hFFFFFFD4);
        // swl / lwl
        st(M_WORD, 65528, 32'h0);
        for (int k = 0; k < 4; k++) begin
            st(M_LEFT, 65528 + k, 32'h12345678);
            ld(M_WORD, 0, 65528, sw_exp[k]);
            ld(M_LEFT, 0, 65528 + k, lwl_exp[k]);
        end
        st(M_LEFT, 65529, 32'hABCD0000);
        ld(M_WORD, 0, 65528, 32'h1234ABCD);
        ld(M_LEFT, 0, 65529, 32'hABCD0000);
        // swr / lwr
        st(M_WORD, 65528, 32'h0);
        for (int k = 0; k < 4; k++) begin
            st(M_RIGHT, 65531 - k, 32'h12345678);
            ld(M_WORD, 0, 65528, sr_exp[k]);
            ld(M_RIGHT, 0, 65531 - k, lwr_exp[k]);
        end
        st(M_RIGHT, 65531, 32'h0000ABCD);
        ld(M_WORD, 0, 65528, 32'hCD345678);
        // reserved modes, aliasing, unsigned ignored on WORD
        st(3'd7, 65528, 32'hDEADBEEF);
        st(3'd6, 65528, 32'hDEADBEEF);
        ld(M_WORD, 1, 65528, 32'hCD345678);
        ld(3'd6, 0, 65528, 32'h0);
        ld(M_NONE, 1, 65528, 32'h0);
        ld(M_WORD, 0, 32'hABCDFFF8, 32'hCD345678);
        st(M_WORD, 32'h0001FFF8, 32'h01020304);
        ld(M_WORD, 0, 65528, 32'h01020304);
        // same-cycle write and read returns old contents
        add(M_WORD, M_WORD, 1'b0, 65528, 32'h0BADF00D, 1'b1, 32'h01020304);
        ld(M_WORD, 0, 65528, 32'h0BADF00D);
    endfunction

    // ---------------- byte-level reference model ----------------
    logic [7:0] mb [0:65535];

    function automatic logic [31:0] model_load(logic [2:0] rm, logic uns, logic [31:0] a);
        int unsigned ad   = int'(a[15:0]);
        int unsigned base = ad & 32'hFFFC;
        int unsigned k    = ad & 3;
        logic [31:0] r = 32'h0;
        logic [7:0]  b;
        logic [15:0] h;
        case (rm)
            M_BYTE: begin
                b = mb[ad];
                r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            end
            M_HALF: begin
                h = {mb[(ad & 32'hFFFE) + 1], mb[ad & 32'hFFFE]};
                r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            M_WORD:  for (int j = 0; j < 4; j++) r[8*j +: 8] = mb[base + j];
            M_LEFT:  for (int j = 0; j <= int'(k); j++) r[8*(3 - int'(k) + j) +: 8] = mb[base + j];
            M_RIGHT: for (int j = int'(k); j < 4; j++) r[8*(j - int'(k)) +: 8] = mb[base + j];
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic void model_store(logic [2:0] wm, logic [31:0] a, logic [31:0] d);
        int unsigned ad   = int'(a[15:0]);
        int unsigned base = ad & 32'hFFFC;
        int unsigned k    = ad & 3;
        case (wm)
            M_BYTE: mb[ad] = d[7:0];
            M_HALF: begin
                mb[ad & 32'hFFFE]       = d[7:0];
                mb[(ad & 32'hFFFE) + 1] = d[15:8];
            end
            M_WORD:  for (int j = 0; j < 4; j++) mb[base + j] = d[8*j +: 8];
            M_LEFT:  for (int i = 0; i <= int'(k); i++) mb[base + k - i] = d[8*(3 - i) +: 8];
            M_RIGHT: for (int i = 0; i <= 3 - int'(k); i++) mb[base + k + i] = d[8*i +: 8];
            default: ;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r1, r2, exp_d, exp_pc;

        rst = 1'b1;
        address = '0; data = '0; writeMode = M_NONE; readMode = M_NONE;
        unsignedLoad = 1'b0; pcAddress = '0;

        // reset state
        #2 rst = 1'b0;
        #1;
        check("reset_data", dataOutput, 32'h0);
        check("reset_pc", pcDataOutput, 32'h0);
        readMode = M_WORD;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_data", dataOutput, 32'h0);
        check("reset_hold_pc", pcDataOutput, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        readMode = M_NONE;

        // directed table
        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            writeMode    = vecs[i].wm;
            readMode     = vecs[i].rm;
            unsignedLoad = vecs[i].uns;
            address      = vecs[i].addr;
            data         = vecs[i].dat;
            @(posedge clk);
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), dataOutput, vecs[i].exp);
        end

        // PC port: words 0..4 at 0,4,...,16
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            writeMode = M_WORD; readMode = M_NONE;
            address = 32'(4 * i); data = 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            writeMode = M_NONE; readMode = M_WORD;
            address = 32'(4 * (4 - i));
            pcAddress = 32'(4 * i);
            @(posedge clk);
            #1;
            check($sformatf("pc_step%0d", i), pcDataOutput, 32'(i));
            check($sformatf("pc_data%0d", i), dataOutput, 32'(4 - i));
            if (i == 2) break;
        end
        // asynchronous reset mid-stream
        #2 rst = 1'b0;
        #1;
        check("midreset_data", dataOutput, 32'h0);
        check("midreset_pc", pcDataOutput, 32'h0);
        // store during reset still commits; outputs stay low
        @(negedge clk);
        writeMode = M_WORD; readMode = M_WORD;
        address = 20; data = 32'h000055AA; pcAddress = 20;
        @(posedge clk);
        #1;
        check("inreset_data", dataOutput, 32'h0);
        check("inreset_pc", pcDataOutput, 32'h0);
        @(negedge clk);
        writeMode = M_NONE;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release_data", dataOutput, 32'h000055AA);
        check("release_pc", pcDataOutput, 32'h000055AA);

        // randomized traffic on a 64-byte window at 0x0100 with aliasing
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            r1 = $urandom();
            writeMode = M_WORD; readMode = M_NONE;
            address = 32'h0100 + 32'(4 * i); data = r1;
            model_store(M_WORD, address, r1);
        end
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            r1 = $urandom();
            r2 = $urandom();
            writeMode    = 3'($urandom_range(0, 7));
            readMode     = 3'($urandom_range(0, 7));
            unsignedLoad = 1'($urandom_range(0, 1));
            address      = {r1[31:16], 10'h004, r1[5:0]};
            pcAddress    = {r2[31:16], 10'h004, r2[5:0]};
            data         = $urandom();
            exp_d  = model_load(readMode, unsignedLoad, address);
            exp_pc = model_load(M_WORD, 1'b0, {pcAddress[31:2], 2'b00});
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_data", n), dataOutput, exp_d);
            check($sformatf("rnd%0d_pc", n), pcDataOutput, exp_pc);
            model_store(writeMode, address, data);
        end

        @(negedge clk);
        writeMode = M_NONE; readMode = M_NONE;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
